// File: rtl/mul_ctrl.sv
// Execute-stage controller for the iterative unsigned multiplier: decode, operand
// conditioning, launch, sign correction and result hold. Optional: MUL_CTRL_ZERO_FAST_EN.
module mul_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    input  logic        allowin,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] result,
    output logic        mul_in_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_out_valid,
    input  logic [31:0] mul_result_h,
    input  logic [31:0] mul_result_l
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SEL_MUL_W   = 2'b00,
        SEL_MULH_W  = 2'b01,
        SEL_MULH_WU = 2'b10
    } sel_t;

    state_t      state_r;
    state_t      state_nxt_s;
    sel_t        sel_s;

    logic [31:0] opa_r;
    logic [31:0] opb_r;
    logic        neg_r;
    logic        hi_r;
    logic [31:0] result_r;
    logic        res_valid_r;

    logic [31:0] cond_a_s;
    logic [31:0] cond_b_s;
    logic        cond_neg_s;
    logic        cond_hi_s;
    logic        zero_op_s;
    logic        launch_s;
    logic        fast_s;
    logic        capture_s;
    logic [63:0] product_s;
    logic [63:0] signed_prod_s;
    logic [31:0] word_s;

    // Magnitude of a two's-complement word; 0x80000000 maps onto itself.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Opcode decode with mulh_wu > mulh_w > mul_w priority; no bit set means MUL.W.
    always_comb begin
        sel_s = SEL_MUL_W;
        casez (op)
            3'b1??:  sel_s = SEL_MULH_WU;
            3'b01?:  sel_s = SEL_MULH_W;
            3'b001:  sel_s = SEL_MUL_W;
            default: sel_s = SEL_MUL_W;
        endcase
    end

    // Operand conditioning so the unsigned core sees magnitudes for MULH.W.
    always_comb begin
        cond_a_s   = src1;
        cond_b_s   = src2;
        cond_neg_s = 1'b0;
        cond_hi_s  = 1'b0;
        case (sel_s)
            SEL_MULH_W: begin
                cond_a_s   = abs32(src1);
                cond_b_s   = abs32(src2);
                cond_neg_s = src1[31] ^ src2[31];
                cond_hi_s  = 1'b1;
            end
            SEL_MULH_WU: begin
                cond_hi_s  = 1'b1;
            end
            SEL_MUL_W: begin
                cond_hi_s  = 1'b0;
            end
            default: begin
                cond_hi_s  = 1'b0;
            end
        endcase
    end

    // Accept / launch / capture qualifiers.
    always_comb begin
        zero_op_s = (src1 == 32'd0) || (src2 == 32'd0);
`ifdef MUL_CTRL_ZERO_FAST_EN
        // Zero operand short-circuits the core entirely, even while it drains.
        fast_s   = (state_r == IDLE) && op_valid && !flush && zero_op_s;
        launch_s = (state_r == IDLE) && op_valid && !flush && mul_out_valid && !zero_op_s;
`else
        fast_s   = 1'b0;
        launch_s = (state_r == IDLE) && op_valid && !flush && mul_out_valid;
`endif
        capture_s = (state_r == WAIT) && mul_out_valid && !flush;
    end

    // Sign correction of the 64-bit product and word selection.
    always_comb begin
        product_s = {mul_result_h, mul_result_l};
        if (neg_r) begin
            signed_prod_s = neg64(product_s);
        end else begin
            signed_prod_s = product_s;
        end
        if (hi_r) begin
            word_s = signed_prod_s[63:32];
        end else begin
            word_s = signed_prod_s[31:0];
        end
    end

    // Next-state logic; flush overrides accept and allowin.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fast_s) begin
                    state_nxt_s = DONE;
                end else if (launch_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (mul_out_valid) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                if (flush || allowin) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conditioned operands held stable for the core while the op is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_r <= 32'd0;
            opb_r <= 32'd0;
            neg_r <= 1'b0;
            hi_r  <= 1'b0;
        end else if (launch_s) begin
            opa_r <= cond_a_s;
            opb_r <= cond_b_s;
            neg_r <= cond_neg_s;
            hi_r  <= cond_hi_s;
        end else begin
            opa_r <= opa_r;
            opb_r <= opb_r;
            neg_r <= neg_r;
            hi_r  <= hi_r;
        end
    end

    // Result register and its valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= 32'd0;
            res_valid_r <= 1'b0;
        end else if (flush) begin
            result_r    <= result_r;
            res_valid_r <= 1'b0;
        end else if (capture_s) begin
            result_r    <= word_s;
            res_valid_r <= 1'b1;
        end else if (fast_s) begin
            result_r    <= 32'd0;
            res_valid_r <= 1'b1;
        end else if ((state_r == DONE) && allowin) begin
            result_r    <= result_r;
            res_valid_r <= 1'b0;
        end else begin
            result_r    <= result_r;
            res_valid_r <= res_valid_r;
        end
    end

    // Launch pulse, operand mux and stall; forced quiet while reset is held.
    always_comb begin
        result       = result_r;
        res_valid    = res_valid_r;
        mul_in_valid = 1'b0;
        mul_a        = 32'd0;
        mul_b        = 32'd0;
        stallreq     = 1'b0;
        if (reset) begin
            mul_in_valid = 1'b0;
        end else begin
            mul_in_valid = launch_s;
            stallreq     = op_valid && (state_r != DONE);
            if (state_r == IDLE) begin
                mul_a = cond_a_s;
                mul_b = cond_b_s;
            end else begin
                mul_a = opa_r;
                mul_b = opb_r;
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: behavioural core model plus arithmetic reference.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        allowin;
    logic        stallreq;
    logic        res_valid;
    logic [31:0] result;
    logic        mul_in_valid;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_out_valid;
    logic [31:0] mul_result_h;
    logic [31:0] mul_result_l;

    int          n_checks = 0;
    int          n_errors = 0;
    int          core_extra = 0;
    int          core_cnt = 0;
    logic [63:0] core_prod = 64'd0;

`ifdef MUL_CTRL_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    mul_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op            (op),
        .src1          (src1),
        .src2          (src2),
        .flush         (flush),
        .allowin       (allowin),
        .stallreq      (stallreq),
        .res_valid     (res_valid),
        .result        (result),
        .mul_in_valid  (mul_in_valid),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_out_valid (mul_out_valid),
        .mul_result_h  (mul_result_h),
        .mul_result_l  (mul_result_l)
    );

    // Unsigned multiplier core: busy for 2+core_extra cycles after a launch.
    always @(posedge clk) begin
        if (reset) begin
            core_cnt <= 0;
        end else if (mul_in_valid) begin
            core_cnt  <= 2 + core_extra;
            core_prod <= {32'd0, mul_a} * {32'd0, mul_b};
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign mul_out_valid = (core_cnt == 0);
    assign mul_result_h  = core_prod[63:32];
    assign mul_result_l  = core_prod[31:0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result straight from the instruction definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        if (o[2]) begin
            ea = {32'd0, a};
            eb = {32'd0, b};
            p  = ea * eb;
            return p[63:32];
        end else if (o[1]) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
            p  = ea * eb;
            return p[63:32];
        end else begin
            return a * b;
        end
    endfunction

    task automatic wait_core_idle();
        int t = 0;
        @(negedge clk);
        while (!mul_out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("core_idle", {31'd0, mul_out_valid}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int extra, input int hold);
        int          c = 0;
        int          lat = -1;
        int          pulses = 0;
        int          stall_bad = 0;
        bit          got = 1'b0;
        bit          zf;
        int          exp_lat;
        logic [31:0] exp;
        zf      = FAST && (a == 32'd0 || b == 32'd0);
        exp_lat = zf ? 1 : 4 + extra;
        exp     = ref_result(o, a, b);
        wait_core_idle();
        @(posedge clk);
        #1;
        op_valid   = 1'b1;
        op         = o;
        src1       = a;
        src2       = b;
        allowin    = (hold == 0);
        core_extra = extra;
        while (!got && c < 40) begin
            @(negedge clk);
            if (mul_in_valid) pulses++;
            if (res_valid) begin
                got = 1'b1;
                lat = c;
            end else begin
                if (!stallreq) stall_bad++;
                c++;
            end
        end
        check_val({tag, "_seen"}, {31'd0, got}, 32'd1);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_result"}, result, exp);
        check_val({tag, "_stall_busy"}, stall_bad, 32'd0);
        check_val({tag, "_stall_done"}, {31'd0, stallreq}, 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (mul_in_valid) pulses++;
            check_val({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
            check_val({tag, "_hold_result"}, result, exp);
            check_val({tag, "_hold_stall"}, {31'd0, stallreq}, 32'd0);
        end
        allowin  = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_exit"}, {31'd0, res_valid}, 32'd0);
        check_val({tag, "_pulses"}, pulses, zf ? 32'd0 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          acc;
        int          resc;
        int          stale;
        int          early;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        flush = 1'b0; allowin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check_val("rst_in_valid", {31'd0, mul_in_valid}, 32'd0);
        check_val("rst_mul_a", mul_a, 32'd0);
        check_val("rst_mul_b", mul_b, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        do_op("mulw", 3'b001, 32'd7, 32'hFFFF_FFFD, 0, 0);
        do_op("mulhw_min", 3'b010, 32'h8000_0000, 32'h8000_0000, 0, 0);
        do_op("mulhw_m1", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        do_op("mulhw_mix", 3'b010, 32'h0001_2345, 32'hFFFF_0000, 0, 0);
        do_op("mulhwu", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op("mulw_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op("op_zero", 3'b000, 32'h0000_1234, 32'h0000_0100, 0, 0);
        do_op("op_prio", 3'b111, 32'h8000_0001, 32'h0000_0003, 0, 0);
        do_op("backpr", 3'b010, 32'hFFFF_FFF0, 32'h1000_0000, 0, 3);
        do_op("zero_fast", 3'b010, 32'd0, 32'd5, 0, 0);
        do_op("slow_core", 3'b001, 32'h0001_0001, 32'h0000_FFFF, 5, 1);

        // Flush while the core is slow; the next op must wait for the core to drain.
        wait_core_idle();
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = 3'b010; src1 = 32'h0000_1234; src2 = 32'h0567_8000;
        allowin = 1'b1; core_extra = 3;
        @(negedge clk);
        check_val("fl_launch", {31'd0, mul_in_valid}, 32'd1);
        @(posedge clk);
        #1 core_extra = 0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; op = 3'b001; src1 = 32'd7; src2 = 32'hFFFF_FFFD;
        @(negedge clk);
        check_val("fl_blocked_stall", {31'd0, stallreq}, 32'd1);
        check_val("fl_blocked_launch", {31'd0, mul_in_valid}, 32'd0);
        acc = (mul_in_valid) ? 3 : -1;
        resc = -1; stale = 0; early = 0;
        for (int c = 4; c < 40 && resc < 0; c++) begin
            @(negedge clk);
            if (mul_in_valid && !mul_out_valid) early++;
            if (mul_in_valid && acc < 0) acc = c;
            if (res_valid) begin
                if (acc < 0) stale++;
                resc = c;
            end
        end
        check_val("fl_accept_cycle", acc, 32'd6);
        check_val("fl_early_launch", early, 32'd0);
        check_val("fl_stale", stale, 32'd0);
        check_val("fl_latency", resc - acc, 32'd4);
        check_val("fl_result", result, 32'hFFFF_FFEB);
        op_valid = 1'b0;
        @(negedge clk);
        check_val("fl_exit", {31'd0, res_valid}, 32'd0);

        // Reset asserted while waiting on the core.
        wait_core_idle();
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = 3'b001; src1 = 32'd9; src2 = 32'd9; core_extra = 0;
        @(posedge clk);
        #1;
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_val("rw_res_valid", {31'd0, res_valid}, 32'd0);
        check_val("rw_result", result, 32'd0);
        check_val("rw_stallreq", {31'd0, stallreq}, 32'd0);
        check_val("rw_in_valid", {31'd0, mul_in_valid}, 32'd0);
        check_val("rw_mul_a", mul_a, 32'd0);
        check_val("rw_mul_b", mul_b, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'h8000_0000;
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_op("rnd", ro, ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
